// File: rtl/jtkcpu_mdu.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide, one step per cen cycle.
// MULS/DIVS sign handling exists only when JTKCPU_MDU_SIGNED_EN is defined; otherwise mode[0] is ignored.
module jtkcpu_mdu #(
  parameter int W = 16
) (
  input  logic         rst,
  input  logic         clk,
  input  logic         cen,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] opnd0,
  input  logic [W-1:0] opnd1,
  output logic [W-1:0] rslt,
  output logic [W-1:0] rslt_hi,
  output logic [3:0]   flags,
  output logic         busy,
  output logic         done
);

`ifdef JTKCPU_MDU_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  localparam int            CW   = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    m_q, m_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            div_q, div_d;
  logic            sgn_q, sgn_d;
  logic            div0_q, div0_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [W-1:0]    rslt_q, rslt_d;
  logic [W-1:0]    rhi_q, rhi_d;
  logic [3:0]      flags_q, flags_d;

  logic            sgn_in, neg0, neg1;
  logic [W-1:0]    mag0, mag1;
  logic [W:0]      sum;
  logic [W:0]      shf;
  logic            ge;
  logic [W-1:0]    dif;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    quo, rem;

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*W-1:0] cond_neg2(input logic [2*W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  // Operands are reduced to magnitudes at load; signs are reapplied in FIX.
  assign sgn_in = SIGNED_EN & mode[0];
  assign neg0   = sgn_in & opnd0[W-1];
  assign neg1   = sgn_in & opnd1[W-1];
  assign mag0   = cond_neg(opnd0, neg0);
  assign mag1   = cond_neg(opnd1, neg1);

  assign sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
  assign shf  = {hi_q, lo_q[W-1]};
  assign ge   = shf >= {1'b0, m_q};
  assign dif  = W'(shf - {1'b0, m_q});

  assign prod = cond_neg2({hi_q, lo_q}, negq_q);
  assign quo  = cond_neg(lo_q, negq_q);
  assign rem  = cond_neg(hi_q, negr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    sgn_d   = sgn_q;
    div0_d  = div0_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    rslt_d  = rslt_q;
    rhi_d   = rhi_q;
    flags_d = flags_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          hi_d    = '0;
          div_d   = mode[1];
          sgn_d   = sgn_in;
          negq_d  = neg0 ^ neg1;
          negr_d  = neg0;
          div0_d  = 1'b0;
          if (mode[1]) begin
            m_d  = mag1;
            lo_d = mag0;
          end else begin
            m_d  = mag0;
            lo_d = mag1;
          end
          // Divide by zero bypasses the iteration; lo keeps the raw dividend for rslt_hi.
          if (mode[1] && opnd1 == '0) begin
            state_d = FIX;
            div0_d  = 1'b1;
            lo_d    = opnd0;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (div_q) begin
          hi_d = ge ? dif : shf[W-1:0];
          lo_d = {lo_q[W-2:0], ge};
        end else begin
          hi_d = sum[W:1];
          lo_d = {sum[0], lo_q[W-1:1]};
        end
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (div0_q) begin
          rslt_d  = '1;
          rhi_d   = lo_q;
          flags_d = 4'b1011;
        end else if (div_q) begin
          // Only -2^(W-1) / -1 yields a positive quotient with the top magnitude bit set.
          rslt_d  = quo;
          rhi_d   = rem;
          flags_d = {quo[W-1], quo == '0, sgn_q & ~negq_q & lo_q[W-1], 1'b0};
        end else begin
          rslt_d  = prod[W-1:0];
          rhi_d   = prod[2*W-1:W];
          flags_d = {prod[2*W-1], prod == '0, 1'b0, prod[W-1]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (cen) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
      div0_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      rslt_q  <= '0;
      rhi_q   <= '0;
      flags_q <= '0;
    end else if (cen) begin
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      sgn_q   <= sgn_d;
      div0_q  <= div0_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      rslt_q  <= rslt_d;
      rhi_q   <= rhi_d;
      flags_q <= flags_d;
    end
  end

  assign rslt    = rslt_q;
  assign rslt_hi = rhi_q;
  assign flags   = flags_q;
  assign busy    = (state_q == RUN) || (state_q == FIX);
  assign done    = (state_q == DONE);

endmodule

// File: doc/jtkcpu_mdu.md
JTKCPU_MDU -- requirements
Module: jtkcpu_mdu

Interface
REQ-001 SHALL have parameter W, default 16, operand width; legal values are even numbers from 8 to 32.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port cen, input, 1 bit: clock enable; state is held while cen=0.
REQ-005 SHALL have port start, input, 1 bit: request to begin an operation.
REQ-006 SHALL have port mode, input, 2 bits: 00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
REQ-007 SHALL have port opnd0, input, W bits: multiplicand or dividend.
REQ-008 SHALL have port opnd1, input, W bits: multiplier or divisor.
REQ-009 SHALL have port rslt, output, W bits: product low half or quotient.
REQ-010 SHALL have port rslt_hi, output, W bits: product high half or remainder.
REQ-011 SHALL have port flags, output, 4 bits: {n,z,v,c}.
REQ-012 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cen-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FIX, DONE, and SHALL advance only on edges where cen=1.
REQ-015 SHALL accept start only in IDLE or DONE; it SHALL latch mode, opnd0 and opnd1, set busy=1 on the same edge, and enter RUN.
REQ-016 SHALL ignore start while busy=1; later changes on the operand inputs SHALL NOT affect the running operation.
REQ-017 In RUN, SHALL perform one radix-2 step per cen cycle for exactly W steps.
- MUL: shift-add.
- DIV: restoring divide on operand magnitudes.
REQ-018 In FIX, SHALL apply sign correction, register rslt, rslt_hi and flags, clear busy, and enter DONE.
- Busy is therefore high for W+1 cen cycles.
REQ-019 In DONE, SHALL hold done=1 for one cen cycle, then return to IDLE; a start arriving in DONE SHALL begin a new operation back-to-back.
REQ-020 SHALL hold rslt, rslt_hi and flags stable from FIX until the next FIX.
REQ-021 MUL: {rslt_hi,rslt} SHALL equal the full 2W-bit product; MULS treats both operands as two's complement.
- MUL flags: v=0; c=rslt[W-1].
REQ-022 DIV: quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend; v=0 and c=0 in normal cases.
REQ-023 Divide by zero SHALL skip RUN and go straight from start to FIX.
- Result: rslt=all ones, rslt_hi=opnd0, v=1, c=1.
- Busy is high for 1 cen cycle.
REQ-024 DIVS with -2^(W-1) / -1 SHALL yield rslt=2^(W-1), rslt_hi=0, v=1, with full latency.
REQ-025 z SHALL be 1 when the result is zero: the full 2W product for MUL, or the quotient for DIV.
REQ-026 n SHALL equal rslt_hi[W-1] for MUL and rslt[W-1] for DIV.

Reset
REQ-027 While rst=1, regardless of clk and cen:
- The FSM SHALL be in IDLE.
- busy, done, rslt, rslt_hi and flags SHALL be 0.
- The step counter and working registers SHALL be 0.
REQ-028 Reset during RUN or FIX SHALL abort the operation with no done pulse; the first start after rst falls SHALL be accepted normally.

Configuration
REQ-029 With macro JTKCPU_MDU_SIGNED_EN defined, SHALL implement MULS and DIVS as specified above.
REQ-030 Without JTKCPU_MDU_SIGNED_EN:
- mode[0] SHALL be ignored and all operations treated as unsigned.
- FIX SHALL perform no sign correction and REQ-024 does not apply.
- Latency SHALL be unchanged.

Verification
REQ-031 W=16, MULU 0x1234 x 0x5678 -> rslt_hi=0x0626, rslt=0x0060, n=0, z=0, c=0, v=0; busy high for 17 cen cycles, then done pulses once.
REQ-032 W=16, MULS 0xFFFD x 0x0005 -> rslt_hi=0xFFFF, rslt=0xFFF1, n=1, c=1; without SIGNED_EN -> rslt_hi=0x0004, rslt=0xFFF1.
REQ-033 W=16, DIVS 0xFFF9 / 0x0002 -> rslt=0xFFFD, rslt_hi=0xFFFF, n=1; without SIGNED_EN -> rslt=0x7FFC, rslt_hi=0x0001.
REQ-034 W=16, DIVU 0x1234 / 0 -> rslt=0xFFFF, rslt_hi=0x1234, v=1, c=1, busy high for 1 cen cycle; and DIVS 0x8000 / 0xFFFF -> rslt=0x8000, rslt_hi=0, v=1.
REQ-035 cen toggled at 1/3 duty with start pulsed again mid-RUN -> latency counted in cen cycles is unchanged, the second start is ignored, and the result is unaltered.
REQ-036 rst pulsed at RUN step 5 -> all outputs go to 0 immediately with no done pulse; a following MULU 3 x 4 -> rslt=0x000C.
